// File: rtl/beep_mixer.sv
// beep_mixer: mixes background music with two prioritised sound effects
// (shot, hit) onto a single buzzer output, with a debounced mute toggle.
// The effect tones and durations are set by parameters in clk cycles.

module beep_mixer #(
    parameter int SHOT_HALF = 25000,
    parameter int HIT_HALF  = 100000,
    parameter int SHOT_LEN  = 5000000,
    parameter int HIT_LEN   = 10000000,
    parameter int DEB_CYC   = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic music_in,
    input  logic shot_evt,
    input  logic hit_evt,
    input  logic mute_btn,
    output logic beep_out,
    output logic sfx_busy,
    output logic muted
);

    // Counter widths follow the largest value each counter must hold.
    localparam int DUR_MAX  = (SHOT_LEN  > HIT_LEN)  ? SHOT_LEN  : HIT_LEN;
    localparam int TONE_MAX = (SHOT_HALF > HIT_HALF) ? SHOT_HALF : HIT_HALF;
    localparam int DUR_W    = $clog2(DUR_MAX + 1);
    localparam int TONE_W   = $clog2(TONE_MAX + 1);
    localparam int DEB_W    = $clog2(DEB_CYC + 1);

    localparam logic [DUR_W-1:0]  SHOT_LAST  = DUR_W'(SHOT_LEN - 1);
    localparam logic [DUR_W-1:0]  HIT_LAST   = DUR_W'(HIT_LEN - 1);
    localparam logic [TONE_W-1:0] SHOT_TLAST = TONE_W'(SHOT_HALF - 1);
    localparam logic [TONE_W-1:0] HIT_TLAST  = TONE_W'(HIT_HALF - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST   = DEB_W'(DEB_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHOT,
        HIT
    } state_t;

    state_t            state;
    logic [DUR_W-1:0]  dur_cnt;
    logic [TONE_W-1:0] tone_cnt;
    logic              wave;

    logic              sync_meta;
    logic              sync_q;
    logic              deb_level;
    logic [DEB_W-1:0]  deb_cnt;

    logic              start_hit;
    logic              start_shot;
    logic              effect_last;
    logic [TONE_W-1:0] tone_last;

    // A hit always (re)starts; a shot starts only when no hit is requested
    // and a hit is not already playing.
    assign start_hit   = hit_evt;
    assign start_shot  = shot_evt && !hit_evt && (state != HIT);
    assign effect_last = ((state == SHOT) && (dur_cnt == SHOT_LAST)) ||
                         ((state == HIT)  && (dur_cnt == HIT_LAST));
    assign tone_last   = (state == HIT) ? HIT_TLAST : SHOT_TLAST;
    assign sfx_busy    = (state != IDLE);

    // Mute button: 2-flop synchronizer, debounce, toggle on debounced press.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the synchronizer and debounced level reset to 1 so a released
        // button does not register as a press right after reset.
        if (!rst_n) begin
            sync_meta <= 1'b1;
            sync_q    <= 1'b1;
            deb_level <= 1'b1;
            deb_cnt   <= '0;
            muted     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make sync_q take the old
            // sync_meta, giving two real flop stages.
            sync_meta <= mute_btn;
            sync_q    <= sync_meta;
            if (sync_q != deb_level) begin
                if (deb_cnt == DEB_LAST) begin
                    deb_level <= sync_q;
                    deb_cnt   <= '0;
                    if (!sync_q) begin
                        muted <= ~muted;
                    end
                end else begin
                    deb_cnt <= deb_cnt + DEB_W'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // Effect FSM with duration counter and tone generator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dur_cnt  <= '0;
            tone_cnt <= '0;
            wave     <= 1'b0;
        end else if (start_hit) begin
            state    <= HIT;
            dur_cnt  <= '0;
            tone_cnt <= '0;
            wave     <= 1'b0;
        end else if (start_shot) begin
            state    <= SHOT;
            dur_cnt  <= '0;
            tone_cnt <= '0;
            wave     <= 1'b0;
        end else if ((state == IDLE) || effect_last) begin
            state    <= IDLE;
            dur_cnt  <= '0;
            tone_cnt <= '0;
            wave     <= 1'b0;
        end else begin
            dur_cnt <= dur_cnt + DUR_W'(1);
            if (tone_cnt == tone_last) begin
                tone_cnt <= '0;
                wave     <= ~wave;
            end else begin
                tone_cnt <= tone_cnt + TONE_W'(1);
            end
        end
    end

    // Output select: mute wins, then an active effect, then music.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beep_out <= 1'b0;
        end else if (muted) begin
            beep_out <= 1'b0;
        end else if (state != IDLE) begin
            beep_out <= wave;
        end else begin
            beep_out <= music_in;
        end
    end

endmodule

// File: tb/tb_beep_mixer.sv
// tb_beep_mixer: directed, table-driven bench for beep_mixer using
// shortened timing parameters.

module tb_beep_mixer;

    localparam int SHOT_HALF = 4;
    localparam int SHOT_LEN  = 40;
    localparam int HIT_HALF  = 8;
    localparam int HIT_LEN   = 64;
    localparam int DEB_CYC   = 16;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic music_in = 1'b0;
    logic shot_evt = 1'b0;
    logic hit_evt  = 1'b0;
    logic mute_btn = 1'b1;
    logic beep_out;
    logic sfx_busy;
    logic muted;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic music;
        logic shot;
        logic hit;
        logic exp_beep;
        logic exp_busy;
    } vec_t;

    vec_t vecs[15];

    beep_mixer #(
        .SHOT_HALF(SHOT_HALF),
        .HIT_HALF (HIT_HALF),
        .SHOT_LEN (SHOT_LEN),
        .HIT_LEN  (HIT_LEN),
        .DEB_CYC  (DEB_CYC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .music_in(music_in),
        .shot_evt(shot_evt),
        .hit_evt (hit_evt),
        .mute_btn(mute_btn),
        .beep_out(beep_out),
        .sfx_busy(sfx_busy),
        .muted   (muted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        shot_evt = 1'b0;
        hit_evt  = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_shot(input string name);
        shot_evt = 1'b1;
        step();
        shot_evt = 1'b0;
        check({name, " busy on entry"}, sfx_busy, 1'b1);
    endtask

    task automatic pulse_hit(input string name);
        hit_evt = 1'b1;
        step();
        hit_evt = 1'b0;
        check({name, " busy on entry"}, sfx_busy, 1'b1);
    endtask

    // Called right after the edge that entered HIT; music_in held at 0.
    task automatic run_hit(input string name, input int shot_at);
        for (int j = 1; j <= HIT_LEN + 2; j++) begin
            step();
            check($sformatf("%s busy j=%0d", name, j), sfx_busy, j < HIT_LEN);
            check($sformatf("%s beep j=%0d", name, j), beep_out,
                  (j <= HIT_LEN) ? (((j - 1) / HIT_HALF) % 2 == 1) : 1'b0);
            shot_evt = (j == shot_at);
        end
        shot_evt = 1'b0;
    endtask

    // Bounce, then a long press; muted must flip exactly once.
    task automatic press(input logic m0, input string name);
        mute_btn = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("%s bounce i=%0d", name, i), muted, m0);
        end
        mute_btn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("%s gap i=%0d", name, i), muted, m0);
        end
        mute_btn = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            check($sformatf("%s hold i=%0d", name, i), muted,
                  (i >= DEB_CYC + 2) ? ~m0 : m0);
        end
        mute_btn = 1'b1;
        for (int i = 1; i <= 22; i++) begin
            step();
        end
        check({name, " after release"}, muted, ~m0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic prev;

        // Idle passthrough, shot start, then hit preempting in the same table.
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset beep", beep_out, 1'b0);
        check("reset busy", sfx_busy, 1'b0);
        check("reset muted", muted, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            music_in = vecs[i].music;
            shot_evt = vecs[i].shot;
            hit_evt  = vecs[i].hit;
            step();
            check($sformatf("vec%0d beep", i), beep_out, vecs[i].exp_beep);
            check($sformatf("vec%0d busy", i), sfx_busy, vecs[i].exp_busy);
        end
        do_reset();
        check("table reset busy", sfx_busy, 1'b0);

        // Idle passthrough with a 10-cycle toggle; output lags by one edge.
        music_in = 1'b0;
        step();
        prev = 1'b0;
        for (int c = 0; c < 40; c++) begin
            music_in = ((c / 10) % 2) == 1;
            #1;
            check($sformatf("pass hold c=%0d", c), beep_out, prev);
            step();
            check($sformatf("pass beep c=%0d", c), beep_out, music_in);
            check($sformatf("pass busy c=%0d", c), sfx_busy, 1'b0);
            prev = music_in;
        end

        // Single shot: 40 busy cycles, 4-high/4-low tone, then music.
        music_in = 1'b0;
        step();
        pulse_shot("shot");
        for (int k = 1; k <= SHOT_LEN + 5; k++) begin
            step();
            check($sformatf("shot busy k=%0d", k), sfx_busy, k < SHOT_LEN);
            check($sformatf("shot beep k=%0d", k), beep_out,
                  (k <= SHOT_LEN) ? (((k - 1) / SHOT_HALF) % 2 == 1) : 1'b0);
        end
        music_in = 1'b1;
        step();
        check("shot music resumes", beep_out, 1'b1);
        music_in = 1'b0;
        step();

        // Hit preempts a shot 10 cycles in.
        pulse_shot("preempt shot");
        for (int k = 1; k <= 9; k++) begin
            step();
        end
        hit_evt = 1'b1;
        step();
        hit_evt = 1'b0;
        check("preempt busy", sfx_busy, 1'b1);
        check("preempt beep", beep_out, 1'b0);
        run_hit("preempt", -1);

        // Both events together in IDLE pick HIT.
        shot_evt = 1'b1;
        hit_evt  = 1'b1;
        step();
        shot_evt = 1'b0;
        hit_evt  = 1'b0;
        check("priority busy", sfx_busy, 1'b1);
        run_hit("priority", -1);

        // Shot during HIT is ignored.
        pulse_hit("ignore");
        run_hit("ignore", 20);

        // Debounced mute: first press mutes, output forced low even in a shot.
        press(1'b0, "press1");
        music_in = 1'b1;
        step();
        check("muted music", beep_out, 1'b0);
        pulse_shot("muted shot");
        for (int k = 1; k <= SHOT_LEN + 2; k++) begin
            step();
            check($sformatf("muted shot beep k=%0d", k), beep_out, 1'b0);
            check($sformatf("muted shot busy k=%0d", k), sfx_busy, k < SHOT_LEN);
        end
        press(1'b1, "press2");
        step();
        check("unmuted music", beep_out, 1'b1);

        // Reset during HIT aborts immediately.
        music_in = 1'b0;
        step();
        pulse_hit("rst hit");
        for (int j = 1; j <= 10; j++) begin
            step();
        end
        check("rst pre beep", beep_out, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst beep", beep_out, 1'b0);
        check("rst busy", sfx_busy, 1'b0);
        check("rst muted", muted, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        music_in = 1'b1;
        step();
        check("post rst beep hi", beep_out, 1'b1);
        check("post rst busy", sfx_busy, 1'b0);
        music_in = 1'b0;
        step();
        check("post rst beep lo", beep_out, 1'b0);
        check("post rst busy2", sfx_busy, 1'b0);

        // Reset clears the mute state.
        press(1'b0, "press3");
        rst_n = 1'b0;
        #1;
        check("rst clears muted", muted, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post rst2 muted", muted, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
